adc_spi_master: RTL and testbench
=================================

Name: adc_spi_master

Overview:
SPI master serialising one DATA_W-bit frame per request to the external ADC (control/range register writes, conversion reads) and capturing the simultaneous DOUT word.
Sits directly below the ADC controller FSM:
- consumes the controller's enable (m_enable) and the datapath's tx word;
- returns busy (m_busy), rx word and a done strobe to the controller and datapath.
SPI mode fixed at CPOL=1, CPHA=1: SCLK idles high, MOSI driven on the falling edge, MISO sampled on the rising edge.

Parameters:
DATA_W, 16, frame length in bits; MSB first.
CLK_DIV, 2, clk cycles per SCLK half-period; minimum 1.
QUIET_CYC, 4, extra cs_n-high cycles after a frame, used only with the optional feature.

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous, active-low
enable  in  1  frame request; level-sampled in IDLE
tx_data  in  DATA_W  word to send; latched on the cycle the request is accepted
busy  out  1  high from the cycle after acceptance until the frame, and quiet time if enabled, completes
done  out  1  one-cycle pulse; rx_data valid in that cycle
rx_data  out  DATA_W  last received word; held until the next done
sclk  out  1  SPI clock
cs_n  out  1  chip select, active-low
mosi  out  1  serial data out
miso  in  1  serial data in; the ADC drives it on the falling edge

Behaviour:
- Reset (async assert, sync deassert is the system's job): state=IDLE, sclk=1, cs_n=1, mosi=0, busy=0, done=0, rx_data=0, all counters 0.
- Reset asserted mid-frame aborts immediately; no done, rx_data unchanged from reset value.
- Half-tick: counter hc counts 0..CLK_DIV-1; tick when hc==CLK_DIV-1; hc cleared on every state entry.
- IDLE: cs_n=1, sclk=1, busy=0.
  - enable=1 -> latch tx_data into tx shift register, bit_cnt=DATA_W, go LEAD.
  - busy is registered high in the next cycle.
- LEAD (CLK_DIV cycles): cs_n=0, sclk=1, mosi=tx_sr[MSB]. Tick -> LOW.
- LOW (CLK_DIV cycles): sclk=0.
  - On entry (falling edge) mosi=tx_sr[MSB], then tx_sr shifts left.
  - Tick -> HIGH.
- HIGH (CLK_DIV cycles): sclk=1.
  - On entry (rising edge) rx_sr = {rx_sr[DATA_W-2:0], miso} and bit_cnt decrements.
  - Tick and bit_cnt==0 -> TRAIL; tick otherwise -> LOW.
- TRAIL (CLK_DIV cycles): sclk=1, cs_n=0.
  - Tick -> cs_n=1, rx_data<=rx_sr, done=1 for one cycle.
  - Next state is QUIET if ADC_SPI_QUIET_EN is defined, else IDLE.
- Frame timing: cs_n low for CLK_DIV*(2*DATA_W+2) cycles; exactly DATA_W rising edges.
- busy low in the first IDLE cycle after done, so there is a minimum of 1 cs_n-high cycle between frames.
- enable while busy=1: ignored; tx_data changes are not observed.
- enable held high continuously: back-to-back frames, each using the tx_data present at its acceptance cycle.
- Controller handshake: hold enable until busy=1, then drop it. A frame is never lost or duplicated if enable drops in the busy-rise cycle.

Optional Feature:
ADC_SPI_QUIET_EN
- Defined: after TRAIL go to QUIET.
  - QUIET: cs_n=1, sclk=1, busy=1 for QUIET_CYC cycles, then IDLE.
  - Guarantees ADC tQUIET between conversions; done still pulses at TRAIL exit.
- Undefined: QUIET state and its counter do not exist; TRAIL -> IDLE directly.

Decomposition:
- Package adc_pkg:
  - state enum (IDLE, LEAD, LOW, HIGH, TRAIL, QUIET);
  - ADC_DATA_W=16;
  - default CLK_DIV;
  - ADC control/range register command constants shared with the controller and datapath.
- One natural sub-module: spi_half_tick, the half-period counter with clear input and tick output, parameterised by CLK_DIV.

Test Plan:
- CLK_DIV=2, tx_data=16'hA5C3, MISO model returns 16'h3C5A
  -> mosi sampled on sclk rising edges = A5C3; rx_data=3C5A at done; cs_n low 68 cycles; 16 rising edges.
- enable held high, tx_data 16'h1111 then 16'h2222
  -> two frames; exactly 1 cycle cs_n high between them; done pulses twice; second frame sends 2222.
- enable pulsed at frame bit 5 with tx_data=16'hFFFF
  -> ignored; busy stays high; no extra frame; original word fully sent.
- rst_n low during 8th bit
  -> same cycle: cs_n=1, sclk=1, busy=0, mosi=0; no done; after release, frame 16'h0F0F completes correctly.
- CLK_DIV=1, tx_data=16'h8001
  -> cs_n low 34 cycles; sclk toggles every cycle; rx loopback equals 8001.
- ADC_SPI_QUIET_EN defined, QUIET_CYC=4
  -> busy remains high 4 cycles after done; cs_n high ≥5 cycles between back-to-back frames.

Source files
------------

// File: rtl/adc_pkg.sv
// Shared definitions for the ADC SPI master and its controller/datapath neighbours:
// frame width, default timing, FSM state encoding and ADC register command words.
package adc_pkg;

    localparam int unsigned ADC_DATA_W        = 16;
    localparam int unsigned ADC_CLK_DIV_DEF   = 2;
    localparam int unsigned ADC_QUIET_CYC_DEF = 4;

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        LOW,
        HIGH,
        TRAIL,
        QUIET
    } spi_state_e;

    // Command word layout: {write, reg_sel[3:0], value[10:0]}; all-zero is a plain conversion read.
    localparam logic       ADC_CMD_WRITE     = 1'b1;
    localparam logic [3:0] ADC_REG_CTRL      = 4'h1;
    localparam logic [3:0] ADC_REG_RANGE     = 4'h2;
    localparam logic [ADC_DATA_W-1:0] ADC_CMD_CONV_READ = '0;

    localparam logic [10:0] ADC_CTRL_DEFAULT  = 11'h010;
    localparam logic [10:0] ADC_RANGE_BIPOLAR = 11'h001;

    function automatic logic [ADC_DATA_W-1:0] adc_wr_cmd(input logic [3:0]  reg_sel,
                                                         input logic [10:0] value);
        return {ADC_CMD_WRITE, reg_sel, value};
    endfunction

endpackage

// File: rtl/spi_half_tick.sv
// Half-period counter for the SPI master: counts 0..CLK_DIV-1 and flags the last count.
module spi_half_tick #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    output logic tick_o
);

    localparam int unsigned HC_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [HC_W-1:0] HC_LAST = HC_W'(CLK_DIV - 1);

    logic [HC_W-1:0] hc_q;
    logic [HC_W-1:0] hc_d;

    assign tick_o = (hc_q == HC_LAST);

    // Wrapping on tick means every state entered on a tick starts from zero.
    always_comb begin
        hc_d = hc_q + HC_W'(1);
        if (clr_i || tick_o) begin
            hc_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hc_q <= '0;
        end else begin
            hc_q <= hc_d;
        end
    end

endmodule

// File: rtl/adc_spi_master.sv
// CPOL=1/CPHA=1 SPI master: one DATA_W-bit MSB-first frame per accepted enable.
// Optional ADC_SPI_QUIET_EN adds a QUIET_CYC-cycle cs_n-high quiet period after each frame.
module adc_spi_master
    import adc_pkg::*;
#(
    parameter int unsigned DATA_W    = ADC_DATA_W,
    parameter int unsigned CLK_DIV   = ADC_CLK_DIV_DEF
`ifdef ADC_SPI_QUIET_EN
    ,
    parameter int unsigned QUIET_CYC = ADC_QUIET_CYC_DEF
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [DATA_W-1:0] tx_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    output logic              sclk,
    output logic              cs_n,
    output logic              mosi,
    input  logic              miso
);

    localparam int unsigned BC_W = $clog2(DATA_W + 1);

`ifdef ADC_SPI_QUIET_EN
    localparam int unsigned QC_W = (QUIET_CYC > 1) ? $clog2(QUIET_CYC) : 1;
    localparam logic [QC_W-1:0] QC_LAST = QC_W'(QUIET_CYC - 1);
    logic [QC_W-1:0] quiet_cnt_q;
`endif

    spi_state_e        state_q;
    logic [DATA_W-1:0] tx_sr_q;
    logic [DATA_W-1:0] rx_sr_q;
    logic [DATA_W-1:0] rx_data_q;
    logic [BC_W-1:0]   bit_cnt_q;
    logic              sclk_q;
    logic              cs_n_q;
    logic              mosi_q;
    logic              busy_q;
    logic              done_q;
    logic              hc_clr;
    logic              tick;

    always_comb begin
        hc_clr = (state_q == IDLE);
`ifdef ADC_SPI_QUIET_EN
        if (state_q == QUIET) begin
            hc_clr = 1'b1;
        end
`endif
    end

    spi_half_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_half_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (hc_clr),
        .tick_o (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            tx_sr_q   <= '0;
            rx_sr_q   <= '0;
            rx_data_q <= '0;
            bit_cnt_q <= '0;
            sclk_q    <= 1'b1;
            cs_n_q    <= 1'b1;
            mosi_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef ADC_SPI_QUIET_EN
            quiet_cnt_q <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (enable) begin
                        tx_sr_q   <= tx_data;
                        bit_cnt_q <= BC_W'(DATA_W);
                        mosi_q    <= tx_data[DATA_W-1];
                        cs_n_q    <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= LEAD;
                    end
                end
                LEAD: begin
                    if (tick) begin
                        sclk_q  <= 1'b0;
                        mosi_q  <= tx_sr_q[DATA_W-1];
                        tx_sr_q <= {tx_sr_q[DATA_W-2:0], 1'b0};
                        state_q <= LOW;
                    end
                end
                LOW: begin
                    if (tick) begin
                        sclk_q    <= 1'b1;
                        rx_sr_q   <= {rx_sr_q[DATA_W-2:0], miso};
                        bit_cnt_q <= bit_cnt_q - BC_W'(1);
                        state_q   <= HIGH;
                    end
                end
                HIGH: begin
                    if (tick) begin
                        if (bit_cnt_q == '0) begin
                            state_q <= TRAIL;
                        end else begin
                            sclk_q  <= 1'b0;
                            mosi_q  <= tx_sr_q[DATA_W-1];
                            tx_sr_q <= {tx_sr_q[DATA_W-2:0], 1'b0};
                            state_q <= LOW;
                        end
                    end
                end
                TRAIL: begin
                    if (tick) begin
                        cs_n_q    <= 1'b1;
                        mosi_q    <= 1'b0;
                        rx_data_q <= rx_sr_q;
                        done_q    <= 1'b1;
`ifdef ADC_SPI_QUIET_EN
                        quiet_cnt_q <= '0;
                        state_q     <= QUIET;
`else
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
`endif
                    end
                end
`ifdef ADC_SPI_QUIET_EN
                QUIET: begin
                    if (quiet_cnt_q == QC_LAST) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        quiet_cnt_q <= quiet_cnt_q + QC_W'(1);
                    end
                end
`endif
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign rx_data = rx_data_q;
    assign sclk    = sclk_q;
    assign cs_n    = cs_n_q;
    assign mosi    = mosi_q;

endmodule

// File: tb/tb_adc_spi_master.sv
// Directed bench for adc_spi_master: scoreboard of expected MOSI/MISO words checked at each done,
// plus a second CLK_DIV=1 instance in MOSI->MISO loopback.
module tb_adc_spi_master;

    localparam int unsigned DW  = 16;
    localparam int unsigned DIV = 2;
    localparam int CS_LOW_EXP = DIV * (2 * DW + 2);
`ifdef ADC_SPI_QUIET_EN
    localparam int GAP_EXP        = 5;
    localparam int BUSY_AFTER_EXP = 4;
`else
    localparam int GAP_EXP        = 1;
    localparam int BUSY_AFTER_EXP = 0;
`endif

    typedef struct {
        logic [DW-1:0] tx;
        logic [DW-1:0] rx;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic [DW-1:0] tx_data = '0;
    logic          busy, done, sclk, cs_n, mosi;
    logic [DW-1:0] rx_data;
    logic          miso_drv = 1'b0;

    logic          enable1 = 1'b0;
    logic [DW-1:0] tx_data1 = '0;
    logic          busy1, done1, sclk1, cs_n1, mosi1;
    logic [DW-1:0] rx_data1;

    int checks = 0;
    int failures = 0;

    exp_t          sb[$];
    logic [DW-1:0] miso_q[$];
    logic [DW-1:0] miso_word = '0;
    logic [DW-1:0] mosi_word = '0;
    int            miso_idx = 0;
    int            cs_low_cnt = 0;
    int            cs_high_cnt = 0;
    int            last_gap = 0;
    int            rises_cur = 0;
    int            done_cnt = 0;
    logic          prev_sclk = 1'b1;
    logic          prev_cs = 1'b1;

    always #5 clk = ~clk;

    adc_spi_master #(
        .DATA_W  (DW),
        .CLK_DIV (DIV)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (enable),
        .tx_data (tx_data),
        .busy    (busy),
        .done    (done),
        .rx_data (rx_data),
        .sclk    (sclk),
        .cs_n    (cs_n),
        .mosi    (mosi),
        .miso    (miso_drv)
    );

    adc_spi_master #(
        .DATA_W  (DW),
        .CLK_DIV (1)
    ) dut_div1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (enable1),
        .tx_data (tx_data1),
        .busy    (busy1),
        .done    (done1),
        .rx_data (rx_data1),
        .sclk    (sclk1),
        .cs_n    (cs_n1),
        .mosi    (mosi1),
        .miso    (mosi1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ADC model and frame monitor for the CLK_DIV=2 instance, sampled mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            cs_low_cnt  = 0;
            cs_high_cnt = 0;
            rises_cur   = 0;
            mosi_word   = '0;
            prev_sclk   = 1'b1;
            prev_cs     = 1'b1;
        end else begin
            if (prev_cs && !cs_n) begin
                last_gap    = cs_high_cnt;
                cs_high_cnt = 0;
                cs_low_cnt  = 0;
                rises_cur   = 0;
                miso_idx    = DW - 1;
                miso_word   = (miso_q.size() > 0) ? miso_q.pop_front() : '0;
            end
            if (!cs_n) cs_low_cnt++;
            else       cs_high_cnt++;
            if (!prev_sclk && sclk) begin
                rises_cur++;
                mosi_word = {mosi_word[DW-2:0], mosi};
            end
            if (prev_sclk && !sclk && !cs_n && miso_idx >= 0) begin
                miso_drv = miso_word[miso_idx];
                miso_idx--;
            end
            if (done) begin
                done_cnt++;
                chk("sb_not_empty", 32'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("rx_data", 32'(rx_data), 32'(e.rx));
                    chk("mosi_word", 32'(mosi_word), 32'(e.tx));
                    chk("sclk_rises", rises_cur, DW);
                    chk("cs_low_cycles", cs_low_cnt, CS_LOW_EXP);
                end
            end
            prev_sclk = sclk;
            prev_cs   = cs_n;
        end
    end

    task automatic push_exp(input logic [DW-1:0] tx, input logic [DW-1:0] rxw);
        exp_t e;
        e.tx = tx;
        e.rx = rxw;
        sb.push_back(e);
        miso_q.push_back(rxw);
    endtask

    task automatic wait_busy();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (busy === 1'b1) break;
        end
        chk("busy_rise", 32'(busy), 1);
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done === 1'b1) break;
        end
        chk("done_seen", 32'(done), 1);
    endtask

    task automatic wait_cs_low(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (cs_n === 1'b0) break;
        end
        chk("cs_fall", 32'(cs_n), 0);
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (busy === 1'b0) break;
            @(negedge clk);
        end
        chk("idle_reached", 32'(busy), 0);
    endtask

    task automatic start(input logic [DW-1:0] tx, input logic [DW-1:0] rxw);
        tx_data = tx;
        enable  = 1'b1;
        push_exp(tx, rxw);
        wait_busy();
        enable = 1'b0;
    endtask

    task automatic wait_rises(input int target);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (rises_cur >= target) break;
        end
        chk("reach_bit", 32'(rises_cur >= target), 1);
    endtask

    initial begin
        int n;
        int base;
        int low;
        int tog;
        logic prev;

        repeat (3) @(negedge clk);
        chk("rst_sclk", 32'(sclk), 1);
        chk("rst_cs_n", 32'(cs_n), 1);
        chk("rst_mosi", 32'(mosi), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_rx_data", 32'(rx_data), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single frame, MSB-first exchange.
        start(16'hA5C3, 16'h3C5A);
        wait_done(200);
        n = 0;
        while (busy === 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("busy_after_done", n, BUSY_AFTER_EXP);
        repeat (2) @(negedge clk);

        // enable held high across two frames; tx_data changes while busy.
        base    = done_cnt;
        tx_data = 16'h1111;
        enable  = 1'b1;
        push_exp(16'h1111, 16'h9AB1);
        wait_busy();
        tx_data = 16'h2222;
        push_exp(16'h2222, 16'h4D2E);
        wait_done(200);
        wait_cs_low(20);
        enable = 1'b0;
        wait_done(200);
        @(negedge clk);
        chk("b2b_done_count", done_cnt - base, 2);
        chk("b2b_cs_gap", last_gap, GAP_EXP);
        wait_idle(20);
        repeat (2) @(negedge clk);

        // Request while busy is ignored.
        start(16'h1234, 16'h9876);
        wait_rises(5);
        tx_data = 16'hFFFF;
        enable  = 1'b1;
        @(negedge clk);
        chk("busy_hold", 32'(busy), 1);
        enable = 1'b0;
        base   = done_cnt;
        wait_done(200);
        @(negedge clk);
        wait_idle(20);
        repeat (5) @(negedge clk);
        chk("no_extra_frame", done_cnt - base, 1);
        chk("idle_cs_n", 32'(cs_n), 1);

        // Reset during the 8th bit aborts the frame.
        start(16'hCAFE, 16'h1357);
        wait_rises(7);
        repeat (2) @(negedge clk);
        base  = done_cnt;
        rst_n = 1'b0;
        #1;
        chk("abort_cs_n", 32'(cs_n), 1);
        chk("abort_sclk", 32'(sclk), 1);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_mosi", 32'(mosi), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_rx_data", 32'(rx_data), 0);
        repeat (3) @(negedge clk);
        chk("abort_no_done", done_cnt - base, 0);
        sb.delete();
        miso_q.delete();
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        start(16'h0F0F, 16'hF0F0);
        wait_done(200);
        @(negedge clk);
        wait_idle(20);
        repeat (2) @(negedge clk);

        // CLK_DIV=1 instance in loopback.
        tx_data1 = 16'h8001;
        enable1  = 1'b1;
        prev     = sclk1;
        @(negedge clk);
        chk("div1_busy", 32'(busy1), 1);
        enable1 = 1'b0;
        low = 0;
        tog = 0;
        for (int i = 0; i < 100; i++) begin
            if (cs_n1 === 1'b0) low++;
            if (sclk1 !== prev) tog++;
            prev = sclk1;
            if (done1 === 1'b1) break;
            @(negedge clk);
        end
        chk("div1_done", 32'(done1), 1);
        chk("div1_cs_low", low, 34);
        chk("div1_sclk_toggles", tog, 32);
        chk("div1_rx_loopback", 32'(rx_data1), 32'h8001);
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
